// File: rtl/ch_digital_seg_ctrl.sv
// ch_digital_seg_ctrl
// ---------------------------------------------------------------------------
// Channel controller for NUM_SEG sampling segments. A qualified discriminator
// edge (hit) optionally waits TRIG_DELAY cycles. It then freezes the next
// 1/2/4/NUM_SEG segments (selected by MODE) by raising their SEG_TRIG bits.
// It also counts accepted hits in a saturating counter. A serializer shifts
// out one segment timestamp, or the hit count, MSB first.
//
// Optional build macro: CH_RING_MODE_EN
//   Adds the RING input. With RING=1 the segment pointer wraps back to 0
//   instead of entering FULL. A reused segment drops its SEG_TRIG for one
//   cycle, so the analog side sees a fresh rising edge.
//
// Ports
//   FCLK                   sampling clock
//   RST                    synchronous active-high reset
//   INST_START             one-cycle pulse, arm the channel (IDLE only)
//   INST_STOP              one-cycle pulse, end sampling
//   INST_READOUT           level, readout window (rising edge enters READOUT)
//   DISCRIMINATOR_OUTPUT   asynchronous discriminator, synchronised here
//   DISCRIMINATOR_POLARITY 1 = rising edge is a hit, 0 = falling edge
//   MODE                   segments per hit: 0->1, 1->2, 2->4, 3->NUM_SEG
//   TRIG_DELAY             extra cycles from hit to capture
//   SEG_CNT                packed segment timestamps, segment i at [i*CNT_W +: CNT_W]
//   SELECT_REG             readout source: segment index, NUM_SEG = hit count
//   SHIFT_EN               advance serializer by one bit
//   RING                   (CH_RING_MODE_EN only) wrap pointer instead of FULL
//   SEG_TRIG               per-segment trigger, high = segment frozen
//   STOP_REQUEST           all segments consumed
//   TRIGGER_CNT            accepted hits, saturating
//   CNT_SER                serial readout bit
// ---------------------------------------------------------------------------
module ch_digital_seg_ctrl #(
    parameter int NUM_SEG = 5,
    parameter int CNT_W   = 10,
    parameter int DLY_W   = 5,
    parameter int TCNT_W  = 4
) (
    input  logic                          FCLK,
    input  logic                          RST,
    input  logic                          INST_START,
    input  logic                          INST_STOP,
    input  logic                          INST_READOUT,
    input  logic                          DISCRIMINATOR_OUTPUT,
    input  logic                          DISCRIMINATOR_POLARITY,
    input  logic [1:0]                    MODE,
    input  logic [DLY_W-1:0]              TRIG_DELAY,
    input  logic [NUM_SEG*CNT_W-1:0]      SEG_CNT,
    input  logic [$clog2(NUM_SEG+1)-1:0]  SELECT_REG,
    input  logic                          SHIFT_EN,
`ifdef CH_RING_MODE_EN
    input  logic                          RING,
`endif
    output logic [NUM_SEG-1:0]            SEG_TRIG,
    output logic                          STOP_REQUEST,
    output logic [TCNT_W-1:0]             TRIGGER_CNT,
    output logic                          CNT_SER
);

    localparam int SEL_W  = $clog2(NUM_SEG+1);
    // Pointer must hold ptr + span, with ptr <= NUM_SEG-1 and span <= NUM_SEG.
    localparam int PTR_W  = $clog2(2*NUM_SEG);
    // MODE=2 asks for four segments; never more than exist.
    localparam int SPAN_M2 = (NUM_SEG < 4) ? NUM_SEG : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_FULL,
        S_READOUT
    } state_t;

    state_t               state_reg;
    logic                 disc_meta_reg;
    logic                 disc_sync_reg;
    logic                 disc_prev_reg;
    logic                 readout_prev_reg;
    logic [DLY_W-1:0]     dly_cnt_reg;
    logic [PTR_W-1:0]     ptr_reg;
    logic [NUM_SEG-1:0]   seg_trig_reg;
    logic [NUM_SEG-1:0]   relight_reg;
    logic                 stop_request_reg;
    logic [TCNT_W-1:0]    trigger_cnt_reg;
    logic [CNT_W-1:0]     shift_reg;

    logic                 hit_evt;
    logic                 readout_rise;
    logic                 ring_on;
    logic [PTR_W-1:0]     span;
    logic [PTR_W-1:0]     ptr_end;
    logic                 wrap;
    logic [NUM_SEG-1:0]   cap_mask;
    logic [NUM_SEG-1:0]   reused;
    logic [NUM_SEG-1:0]   seg_capture;
    logic [TCNT_W-1:0]    tcnt_next;
    logic [CNT_W-1:0]     tcnt_just;
    logic [CNT_W-1:0]     load_word;
    logic [CNT_W-1:0]     seg_word [NUM_SEG];

`ifdef CH_RING_MODE_EN
    assign ring_on = RING;
`else
    assign ring_on = 1'b0;
`endif

    // The edge detector looks at the synchronised value against its previous
    // sample. An input change sampled at edge k is therefore visible to the
    // FSM at edge k+2.
    assign hit_evt = DISCRIMINATOR_POLARITY ? (disc_sync_reg & ~disc_prev_reg)
                                            : (~disc_sync_reg & disc_prev_reg);

    assign readout_rise = INST_READOUT & ~readout_prev_reg;

    always_comb begin
        span = PTR_W'(1);
        case (MODE)
            2'd0:    span = PTR_W'(1);
            2'd1:    span = PTR_W'(2);
            2'd2:    span = PTR_W'(SPAN_M2);
            default: span = PTR_W'(NUM_SEG);
        endcase
    end

    assign ptr_end = ptr_reg + span;
    assign wrap    = (ptr_end >= PTR_W'(NUM_SEG));

    // Segments ptr .. ptr_end-1 are frozen by a capture. Indices past the last
    // segment simply have no bit, which clips the span.
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_mask
        assign cap_mask[gi] = (PTR_W'(gi) >= ptr_reg) && (PTR_W'(gi) < ptr_end);
    end

    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_word
        assign seg_word[gi] = SEG_CNT[gi*CNT_W +: CNT_W];
    end

    // A segment can only be hit twice in one run after a ring wrap. It goes
    // low on the capture cycle and is raised again one cycle later.
    assign reused      = cap_mask & seg_trig_reg & {NUM_SEG{ring_on}};
    assign seg_capture = (seg_trig_reg | cap_mask) & ~reused;

    assign tcnt_next = (&trigger_cnt_reg) ? trigger_cnt_reg
                                          : trigger_cnt_reg + TCNT_W'(1);

    // The hit count is presented MSB-aligned in the CNT_W-wide shift word.
    assign tcnt_just = CNT_W'(trigger_cnt_reg) << (CNT_W - TCNT_W);

    always_comb begin
        load_word = '0;
        if (SELECT_REG < SEL_W'(NUM_SEG)) begin
            load_word = seg_word[SELECT_REG];
        end else if (SELECT_REG == SEL_W'(NUM_SEG)) begin
            load_word = tcnt_just;
        end
    end

    // Discriminator synchroniser and edge history.
    always_ff @(posedge FCLK) begin
        if (RST) begin
            disc_meta_reg <= 1'b0;
            disc_sync_reg <= 1'b0;
            disc_prev_reg <= 1'b0;
        end else begin
            disc_meta_reg <= DISCRIMINATOR_OUTPUT;
            disc_sync_reg <= disc_meta_reg;
            disc_prev_reg <= disc_sync_reg;
        end
    end

    // The readout level keeps being sampled during reset. This stops a window
    // held open across reset from being seen as a new rising edge.
    always_ff @(posedge FCLK) begin
        readout_prev_reg <= INST_READOUT;
    end

    always_ff @(posedge FCLK) begin
        if (RST) begin
            state_reg        <= S_IDLE;
            dly_cnt_reg      <= '0;
            ptr_reg          <= '0;
            seg_trig_reg     <= '0;
            relight_reg      <= '0;
            stop_request_reg <= 1'b0;
            trigger_cnt_reg  <= '0;
            shift_reg        <= '0;
        end else begin
            seg_trig_reg <= seg_trig_reg | relight_reg;
            relight_reg  <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (INST_STOP) begin
                        state_reg <= S_IDLE;
                    end else if (INST_START) begin
                        state_reg       <= S_ARMED;
                        seg_trig_reg    <= '0;
                        trigger_cnt_reg <= '0;
                        ptr_reg         <= '0;
                    end else if (readout_rise) begin
                        state_reg <= S_READOUT;
                        shift_reg <= load_word;
                    end
                end
                S_ARMED: begin
                    if (INST_STOP) begin
                        state_reg <= S_IDLE;
                    end else if (hit_evt) begin
                        state_reg   <= S_DELAY;
                        dly_cnt_reg <= TRIG_DELAY;
                    end
                end
                S_DELAY: begin
                    if (INST_STOP) begin
                        state_reg <= S_IDLE;
                    end else if (dly_cnt_reg == '0) begin
                        seg_trig_reg    <= seg_capture;
                        relight_reg     <= reused;
                        trigger_cnt_reg <= tcnt_next;
                        if (wrap && ring_on) begin
                            ptr_reg   <= '0;
                            state_reg <= S_ARMED;
                        end else if (wrap) begin
                            ptr_reg          <= ptr_end;
                            state_reg        <= S_FULL;
                            stop_request_reg <= 1'b1;
                        end else begin
                            ptr_reg   <= ptr_end;
                            state_reg <= S_ARMED;
                        end
                    end else begin
                        dly_cnt_reg <= dly_cnt_reg - DLY_W'(1);
                    end
                end
                S_FULL: begin
                    if (INST_STOP) begin
                        state_reg        <= S_IDLE;
                        stop_request_reg <= 1'b0;
                    end else if (readout_rise) begin
                        state_reg        <= S_READOUT;
                        stop_request_reg <= 1'b0;
                        shift_reg        <= load_word;
                    end
                end
                S_READOUT: begin
                    if (!INST_READOUT) begin
                        state_reg <= S_IDLE;
                        shift_reg <= '0;
                    end else if (SHIFT_EN) begin
                        shift_reg <= {shift_reg[CNT_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign SEG_TRIG     = seg_trig_reg;
    assign STOP_REQUEST = stop_request_reg;
    assign TRIGGER_CNT  = trigger_cnt_reg;
    assign CNT_SER      = shift_reg[CNT_W-1];

endmodule

// File: tb/tb_ch_digital_seg_ctrl.sv
// Self-checking bench for ch_digital_seg_ctrl (NUM_SEG=5, CNT_W=10).
// A table of hit records drives the capture path. Hand-written sequences
// cover polarity, stop/capture collision, readout, reset and ring mode.
module tb_ch_digital_seg_ctrl;

    localparam int NUM_SEG = 5;
    localparam int CNT_W   = 10;
    localparam int DLY_W   = 5;
    localparam int TCNT_W  = 4;
    localparam int SEL_W   = 3;

    logic                     FCLK = 1'b0;
    logic                     RST;
    logic                     INST_START;
    logic                     INST_STOP;
    logic                     INST_READOUT;
    logic                     DISCRIMINATOR_OUTPUT;
    logic                     DISCRIMINATOR_POLARITY;
    logic [1:0]               MODE;
    logic [DLY_W-1:0]         TRIG_DELAY;
    logic [NUM_SEG*CNT_W-1:0] SEG_CNT;
    logic [SEL_W-1:0]         SELECT_REG;
    logic                     SHIFT_EN;
`ifdef CH_RING_MODE_EN
    logic                     RING;
`endif
    logic [NUM_SEG-1:0]       SEG_TRIG;
    logic                     STOP_REQUEST;
    logic [TCNT_W-1:0]        TRIGGER_CNT;
    logic                     CNT_SER;

    always #5 FCLK = ~FCLK;

    ch_digital_seg_ctrl #(
        .NUM_SEG(NUM_SEG), .CNT_W(CNT_W), .DLY_W(DLY_W), .TCNT_W(TCNT_W)
    ) dut (
        .FCLK(FCLK),
        .RST(RST),
        .INST_START(INST_START),
        .INST_STOP(INST_STOP),
        .INST_READOUT(INST_READOUT),
        .DISCRIMINATOR_OUTPUT(DISCRIMINATOR_OUTPUT),
        .DISCRIMINATOR_POLARITY(DISCRIMINATOR_POLARITY),
        .MODE(MODE),
        .TRIG_DELAY(TRIG_DELAY),
        .SEG_CNT(SEG_CNT),
        .SELECT_REG(SELECT_REG),
        .SHIFT_EN(SHIFT_EN),
`ifdef CH_RING_MODE_EN
        .RING(RING),
`endif
        .SEG_TRIG(SEG_TRIG),
        .STOP_REQUEST(STOP_REQUEST),
        .TRIGGER_CNT(TRIGGER_CNT),
        .CNT_SER(CNT_SER)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit                 restart;
        logic [1:0]         mode;
        int                 dly;
        bit                 dbl;
        logic [NUM_SEG-1:0] trig;
        int                 cnt;
        bit                 stop;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge and sampled at the next.
    task automatic tick;
        @(posedge FCLK);
        #1;
    endtask

    task automatic pulse_start;
        INST_START = 1'b1;
        tick;
        INST_START = 1'b0;
    endtask

    task automatic pulse_stop;
        INST_STOP = 1'b1;
        tick;
        INST_STOP = 1'b0;
    endtask

    // One rising-polarity hit. The input rises at edge k. The capture must not
    // be visible at edge k+2+d and must be visible at edge k+3+d. With dbl set,
    // a second rising edge falls inside the DELAY window and must be ignored.
    task automatic hit_step(input string tag, input int d, input bit dbl,
                            input logic [NUM_SEG-1:0] prev_trig,
                            input logic [NUM_SEG-1:0] exp_trig,
                            input int exp_cnt, input bit exp_stop);
        for (int c = 0; c <= 3 + d; c++) begin
            DISCRIMINATOR_OUTPUT = (dbl && (c == 2 || c == 3)) ? 1'b0 : 1'b1;
            tick;
            if (c == 2 + d) chk($sformatf("%s pre_trig", tag), 32'(SEG_TRIG), 32'(prev_trig));
        end
        chk($sformatf("%s trig", tag), 32'(SEG_TRIG), 32'(exp_trig));
        chk($sformatf("%s cnt", tag), 32'(TRIGGER_CNT), 32'(exp_cnt));
        chk($sformatf("%s stop", tag), 32'(STOP_REQUEST), 32'(exp_stop));
        DISCRIMINATOR_OUTPUT = 1'b0;
        repeat (16) tick;
        chk($sformatf("%s trig_hold", tag), 32'(SEG_TRIG), 32'(exp_trig));
        chk($sformatf("%s cnt_hold", tag), 32'(TRIGGER_CNT), 32'(exp_cnt));
    endtask

    // Opens a readout window and shifts CNT_W+1 times, checking every bit.
    // With chg set, SELECT_REG is moved after the load and must not matter.
    task automatic readout_seq(input string tag, input logic [CNT_W-1:0] word, input bit chg);
        logic exp_bit;
        INST_READOUT = 1'b1;
        tick;
        chk($sformatf("%s bit0", tag), 32'(CNT_SER), 32'(word[CNT_W-1]));
        if (chg) SELECT_REG = 3'd5;
        for (int j = 1; j <= CNT_W + 1; j++) begin
            SHIFT_EN = 1'b1;
            tick;
            exp_bit = (j < CNT_W) ? word[CNT_W-1-j] : 1'b0;
            chk($sformatf("%s bit%0d", tag, j), 32'(CNT_SER), 32'(exp_bit));
        end
        SHIFT_EN     = 1'b0;
        INST_READOUT = 1'b0;
        tick;
        chk($sformatf("%s exit", tag), 32'(CNT_SER), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_SEG-1:0] prev;

        vecs[0]  = '{1'b1, 2'd0, 0, 1'b0, 5'b00001, 1, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 0, 1'b0, 5'b00011, 2, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 0, 1'b0, 5'b00111, 3, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 0, 1'b0, 5'b01111, 4, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 0, 1'b0, 5'b11111, 5, 1'b1};
        vecs[5]  = '{1'b1, 2'd3, 2, 1'b0, 5'b11111, 1, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 1, 1'b0, 5'b01111, 1, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 0, 1'b0, 5'b11111, 2, 1'b1};
        vecs[8]  = '{1'b1, 2'd1, 7, 1'b0, 5'b00011, 1, 1'b0};
        vecs[9]  = '{1'b0, 2'd1, 7, 1'b1, 5'b01111, 2, 1'b0};
        vecs[10] = '{1'b0, 2'd1, 7, 1'b0, 5'b11111, 3, 1'b1};

        RST = 1'b1;
        INST_START = 1'b0;
        INST_STOP = 1'b0;
        INST_READOUT = 1'b0;
        DISCRIMINATOR_OUTPUT = 1'b0;
        DISCRIMINATOR_POLARITY = 1'b1;
        MODE = 2'd0;
        TRIG_DELAY = '0;
        SEG_CNT = {10'h111, 10'h0F0, 10'h2A5, 10'h155, 10'h3C3};
        SELECT_REG = '0;
        SHIFT_EN = 1'b0;
`ifdef CH_RING_MODE_EN
        RING = 1'b0;
`endif
        repeat (3) tick;
        chk("reset seg_trig", 32'(SEG_TRIG), 32'd0);
        chk("reset stop_request", 32'(STOP_REQUEST), 32'd0);
        chk("reset trigger_cnt", 32'(TRIGGER_CNT), 32'd0);
        chk("reset cnt_ser", 32'(CNT_SER), 32'd0);
        RST = 1'b0;
        repeat (2) tick;

        prev = '0;
        for (int i = 0; i < 11; i++) begin
            MODE = vecs[i].mode;
            TRIG_DELAY = DLY_W'(vecs[i].dly);
            if (vecs[i].restart) begin
                pulse_stop;
                pulse_start;
                chk($sformatf("v%0d arm trig", i), 32'(SEG_TRIG), 32'd0);
                chk($sformatf("v%0d arm cnt", i), 32'(TRIGGER_CNT), 32'd0);
                chk($sformatf("v%0d arm stop", i), 32'(STOP_REQUEST), 32'd0);
                prev = '0;
            end
            hit_step($sformatf("v%0d", i), vecs[i].dly, vecs[i].dbl, prev,
                     vecs[i].trig, vecs[i].cnt, vecs[i].stop);
            prev = vecs[i].trig;
        end

        // Readout straight from FULL: hit count 3, left-justified.
        SELECT_REG = 3'd5;
        readout_seq("rd_tcnt", 10'h0C0, 1'b0);
        chk("rd_tcnt seg_trig kept", 32'(SEG_TRIG), 32'h1F);
        SELECT_REG = 3'd2;
        readout_seq("rd_seg2", 10'h2A5, 1'b1);
        SELECT_REG = 3'd7;
        readout_seq("rd_sel7", 10'h000, 1'b0);

        // Falling-edge polarity, then a stop colliding with a capture.
        DISCRIMINATOR_POLARITY = 1'b0;
        DISCRIMINATOR_OUTPUT = 1'b1;
        MODE = 2'd0;
        TRIG_DELAY = '0;
        repeat (4) tick;
        pulse_start;
        DISCRIMINATOR_OUTPUT = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            tick;
            if (c == 2) chk("pol0 pre_trig", 32'(SEG_TRIG), 32'd0);
        end
        chk("pol0 fall trig", 32'(SEG_TRIG), 32'h01);
        chk("pol0 fall cnt", 32'(TRIGGER_CNT), 32'd1);
        repeat (5) tick;
        DISCRIMINATOR_OUTPUT = 1'b1;
        repeat (10) tick;
        chk("pol0 rise ignored trig", 32'(SEG_TRIG), 32'h01);
        chk("pol0 rise ignored cnt", 32'(TRIGGER_CNT), 32'd1);
        DISCRIMINATOR_OUTPUT = 1'b0;
        tick;
        tick;
        tick;
        INST_STOP = 1'b1;
        tick;
        INST_STOP = 1'b0;
        chk("stop_vs_cap trig", 32'(SEG_TRIG), 32'h01);
        chk("stop_vs_cap cnt", 32'(TRIGGER_CNT), 32'd1);
        DISCRIMINATOR_OUTPUT = 1'b1;
        repeat (5) tick;
        DISCRIMINATOR_OUTPUT = 1'b0;
        repeat (10) tick;
        chk("stop_vs_cap idle trig", 32'(SEG_TRIG), 32'h01);
        chk("stop_vs_cap idle cnt", 32'(TRIGGER_CNT), 32'd1);

        // Reset in the middle of a DELAY countdown.
        DISCRIMINATOR_POLARITY = 1'b1;
        repeat (4) tick;
        pulse_start;
        hit_step("rst_pre", 0, 1'b0, 5'b00000, 5'b00001, 1, 1'b0);
        TRIG_DELAY = DLY_W'(7);
        DISCRIMINATOR_OUTPUT = 1'b1;
        repeat (4) tick;
        RST = 1'b1;
        tick;
        chk("rst_dly seg_trig", 32'(SEG_TRIG), 32'd0);
        chk("rst_dly trigger_cnt", 32'(TRIGGER_CNT), 32'd0);
        chk("rst_dly stop_request", 32'(STOP_REQUEST), 32'd0);
        chk("rst_dly cnt_ser", 32'(CNT_SER), 32'd0);
        RST = 1'b0;
        DISCRIMINATOR_OUTPUT = 1'b0;
        repeat (12) tick;
        chk("rst_dly no_capture", 32'(SEG_TRIG), 32'd0);
        TRIG_DELAY = '0;
        pulse_start;
        hit_step("rearm", 0, 1'b0, 5'b00000, 5'b00001, 1, 1'b0);

        // Reset in the middle of a readout window.
        pulse_stop;
        SELECT_REG = 3'd2;
        INST_READOUT = 1'b1;
        tick;
        chk("rst_rd loaded", 32'(CNT_SER), 32'd1);
        RST = 1'b1;
        INST_READOUT = 1'b0;
        tick;
        chk("rst_rd cnt_ser", 32'(CNT_SER), 32'd0);
        chk("rst_rd seg_trig", 32'(SEG_TRIG), 32'd0);
        chk("rst_rd trigger_cnt", 32'(TRIGGER_CNT), 32'd0);
        RST = 1'b0;
        tick;
        readout_seq("rd_after_rst", 10'h2A5, 1'b0);

`ifdef CH_RING_MODE_EN
        // Ring wrap: the third hit reuses segments 0-3.
        RING = 1'b1;
        MODE = 2'd2;
        TRIG_DELAY = '0;
        pulse_start;
        hit_step("ring1", 0, 1'b0, 5'b00000, 5'b01111, 1, 1'b0);
        hit_step("ring2", 0, 1'b0, 5'b01111, 5'b11111, 2, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            DISCRIMINATOR_OUTPUT = 1'b1;
            tick;
        end
        chk("ring3 low_pulse", 32'(SEG_TRIG), 32'h10);
        tick;
        chk("ring3 relit", 32'(SEG_TRIG), 32'h1F);
        chk("ring3 cnt", 32'(TRIGGER_CNT), 32'd3);
        chk("ring3 stop", 32'(STOP_REQUEST), 32'd0);
        DISCRIMINATOR_OUTPUT = 1'b0;
        repeat (5) tick;
        RING = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
